// File: rtl/layer_ctrl.sv
// rtl/layer_ctrl.sv - command/data byte decoder producing RAM write strobes for the LED cube
module layer_ctrl (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       dc_in,
    input  logic       byte_rdy_in,
    input  logic [7:0] byte_data_in,
    output logic [8:0] wr_en_out,
    output logic       wr_done_out,
    output logic [5:0] wr_addr_out,
    output logic [3:0] wr_byte_en_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONF = 2'd1;
    localparam logic [1:0] ST_ADDR = 2'd2;
    localparam logic [1:0] ST_DATA = 2'd3;

    localparam logic [10:0] CONF_LAST = 11'd3;
    localparam logic [10:0] ADDR_LAST = 11'd63;
    localparam logic [10:0] DATA_LAST = 11'd1535;

    logic [1:0]  state;
    logic [10:0] cnt;
    // DATA addressing is tracked as lane/led/layer sub-counters so that no
    // divide-by-192 or divide-by-3 logic is needed on the strobe path.
    logic [1:0]  lane;
    logic [5:0]  led;
    logic [2:0]  layer;
    logic        data_wr;

    assign data_wr = byte_rdy_in & dc_in;

    // Zero-latency decode of the current state and counter into the RAM write controls
    always_comb begin
        wr_en_out      = '0;
        wr_addr_out    = '0;
        wr_byte_en_out = '0;
        case (state)
            ST_CONF: begin
                wr_addr_out    = 6'd16;
                wr_byte_en_out = 4'b0001 << cnt[1:0];
                if (data_wr) wr_en_out = 9'h100;
            end
            ST_ADDR: begin
                wr_addr_out    = {2'b00, cnt[5:2]};
                wr_byte_en_out = 4'b0001 << cnt[1:0];
                if (data_wr) wr_en_out = 9'h100;
            end
            ST_DATA: begin
                wr_addr_out    = led;
                wr_byte_en_out = 4'b0001 << lane;
                if (data_wr) wr_en_out = 9'd1 << layer;
            end
            default: ;
        endcase
    end

    // Command decode, byte counting and the end-of-frame pulse
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            lane        <= '0;
            led         <= '0;
            layer       <= '0;
            wr_done_out <= 1'b0;
        end else begin
            wr_done_out <= 1'b0;
            if (byte_rdy_in) begin
                if (!dc_in) begin
                    cnt   <= '0;
                    lane  <= '0;
                    led   <= '0;
                    layer <= '0;
                    case (byte_data_in)
                        8'h2A:   state <= ST_CONF;
                        8'h2B:   state <= ST_ADDR;
                        8'h2C:   state <= ST_DATA;
                        default: state <= ST_IDLE;
                    endcase
                end else begin
                    case (state)
                        ST_CONF: begin
                            if (cnt == CONF_LAST) begin
                                state <= ST_IDLE;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 11'd1;
                            end
                        end
                        ST_ADDR: begin
                            if (cnt == ADDR_LAST) begin
                                state <= ST_IDLE;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 11'd1;
                            end
                        end
                        ST_DATA: begin
                            if (cnt == DATA_LAST) begin
                                state       <= ST_IDLE;
                                cnt         <= '0;
                                lane        <= '0;
                                led         <= '0;
                                layer       <= '0;
                                wr_done_out <= 1'b1;
                            end else begin
                                cnt <= cnt + 11'd1;
                                if (lane == 2'd2) begin
                                    lane <= '0;
                                    if (led == 6'd63) begin
                                        led   <= '0;
                                        layer <= layer + 3'd1;
                                    end else begin
                                        led <= led + 6'd1;
                                    end
                                end else begin
                                    lane <= lane + 2'd1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_layer_ctrl.sv
// tb/tb_layer_ctrl.sv - self-checking bench for layer_ctrl
module tb_layer_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       dc_in = 1'b0;
    logic       byte_rdy_in = 1'b0;
    logic [7:0] byte_data_in = 8'h00;
    logic [8:0] wr_en_out;
    logic       wr_done_out;
    logic [5:0] wr_addr_out;
    logic [3:0] wr_byte_en_out;

    layer_ctrl dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .dc_in          (dc_in),
        .byte_rdy_in    (byte_rdy_in),
        .byte_data_in   (byte_data_in),
        .wr_en_out      (wr_en_out),
        .wr_done_out    (wr_done_out),
        .wr_addr_out    (wr_addr_out),
        .wr_byte_en_out (wr_byte_en_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;
    int done_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: transfer kind and byte index within it
    localparam int M_IDLE = 0, M_CONF = 1, M_ADDR = 2, M_DATA = 3;
    int mmode = M_IDLE;
    int mcnt  = 0;
    bit mdone = 1'b0;

    function automatic int xfer_len(input int mode);
        case (mode)
            M_CONF:  return 4;
            M_ADDR:  return 64;
            M_DATA:  return 1536;
            default: return 0;
        endcase
    endfunction

    always @(negedge clk_in) begin
        int  e_en, e_addr, e_be, e_done;
        bit  wr, nd;
        e_en = 0; e_addr = 0; e_be = 0; e_done = 0;
        wr = byte_rdy_in && dc_in;
        if (!rst_n_in) begin
            mmode = M_IDLE; mcnt = 0; mdone = 1'b0;
        end else begin
            case (mmode)
                M_CONF: begin
                    e_addr = 16; e_be = 1 << mcnt;
                    if (wr) e_en = 256;
                end
                M_ADDR: begin
                    e_addr = mcnt / 4; e_be = 1 << (mcnt % 4);
                    if (wr) e_en = 256;
                end
                M_DATA: begin
                    e_addr = (mcnt % 192) / 3; e_be = 1 << (mcnt % 3);
                    if (wr) e_en = 1 << (mcnt / 192);
                end
                default: ;
            endcase
            e_done = mdone;
        end
        if (wr_done_out) done_pulses++;
        check("cyc_wr_en", 32'(wr_en_out), e_en);
        check("cyc_addr", 32'(wr_addr_out), e_addr);
        check("cyc_byte_en", 32'(wr_byte_en_out), e_be);
        check("cyc_done", 32'(wr_done_out), e_done);
        check("cyc_onehot", 32'($countones(wr_en_out) <= 1), 1);
        // advance the model to the state after the coming rising edge
        nd = 1'b0;
        if (rst_n_in && byte_rdy_in) begin
            if (!dc_in) begin
                mcnt = 0;
                case (byte_data_in)
                    8'h2A:   mmode = M_CONF;
                    8'h2B:   mmode = M_ADDR;
                    8'h2C:   mmode = M_DATA;
                    default: mmode = M_IDLE;
                endcase
            end else if (mmode != M_IDLE) begin
                if (mcnt == xfer_len(mmode) - 1) begin
                    nd = (mmode == M_DATA);
                    mmode = M_IDLE;
                    mcnt = 0;
                end else begin
                    mcnt++;
                end
            end
        end
        mdone = nd;
    end

    logic [8:0] cap_en;
    logic [5:0] cap_addr;
    logic [3:0] cap_be;
    logic       cap_done;

    task automatic send(input bit dc, input logic [7:0] data);
        @(posedge clk_in); #1;
        dc_in = dc; byte_data_in = data; byte_rdy_in = 1'b1;
        @(negedge clk_in); #1;
        cap_en = wr_en_out; cap_addr = wr_addr_out; cap_be = wr_byte_en_out; cap_done = wr_done_out;
        @(posedge clk_in); #1;
        byte_rdy_in = 1'b0;
    endtask

    task automatic lit(input string name, input logic [8:0] en, input logic [5:0] addr, input logic [3:0] be);
        check({name, "_en"}, 32'(cap_en), 32'(en));
        check({name, "_addr"}, 32'(cap_addr), 32'(addr));
        check({name, "_be"}, 32'(cap_be), 32'(be));
    endtask

    initial begin
        int p0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in); #1;
        check("rst_en", 32'(wr_en_out), 0);
        check("rst_done", 32'(wr_done_out), 0);
        check("rst_addr", 32'(wr_addr_out), 0);
        check("rst_be", 32'(wr_byte_en_out), 0);
        @(posedge clk_in); #1 rst_n_in = 1'b1;

        // 1: timing configuration
        send(1'b0, 8'h2A);
        send(1'b1, 8'h01); lit("conf0", 9'h100, 6'd16, 4'b0001);
        send(1'b1, 8'h12); lit("conf1", 9'h100, 6'd16, 4'b0010);
        send(1'b1, 8'h23); lit("conf2", 9'h100, 6'd16, 4'b0100);
        send(1'b1, 8'h34); lit("conf3", 9'h100, 6'd16, 4'b1000);
        send(1'b1, 8'h45); check("conf_extra_en", 32'(cap_en), 0);

        // 2: channel address map
        send(1'b0, 8'h2B);
        for (int i = 0; i < 64; i++) begin
            send(1'b1, 8'(i));
            if (i == 0)  lit("addr_first", 9'h100, 6'd0, 4'b0001);
            if (i == 6)  lit("addr_6", 9'h100, 6'd1, 4'b0100);
            if (i == 63) lit("addr_last", 9'h100, 6'd15, 4'b1000);
        end
        send(1'b1, 8'hFF); check("addr_extra_en", 32'(cap_en), 0);

        // 3: full colour frame
        p0 = done_pulses;
        send(1'b0, 8'h2C);
        for (int i = 0; i < 1536; i++) begin
            send(1'b1, 8'(i % 255));
            if (i == 0)    lit("data_first", 9'h001, 6'd0, 4'b0001);
            if (i == 191)  lit("data_191", 9'h001, 6'd63, 4'b0100);
            if (i == 192)  lit("data_192", 9'h002, 6'd0, 4'b0001);
            if (i == 1535) lit("data_last", 9'h080, 6'd63, 4'b0100);
            if (i == 1535) check("data_last_nodone", 32'(cap_done), 0);
        end
        @(negedge clk_in); #1 check("done_pulse", 32'(wr_done_out), 1);
        @(negedge clk_in); #1 check("done_cleared", 32'(wr_done_out), 0);
        check("frame_pulses", 32'(done_pulses - p0), 1);

        // 4: data without a valid command
        send(1'b1, 8'h11); check("nocmd_en", 32'(cap_en), 0);
        send(1'b0, 8'h55);
        send(1'b1, 8'h22); check("unk_en", 32'(cap_en), 0);
        check("unk_done", 32'(cap_done), 0);

        // 5: aborted frame then complete frame
        p0 = done_pulses;
        send(1'b0, 8'h2C);
        for (int i = 0; i < 100; i++) send(1'b1, 8'(i));
        send(1'b0, 8'h2C);
        for (int i = 0; i < 1536; i++) begin
            send(1'b1, 8'(i % 255));
            if (i == 0) lit("restart_first", 9'h001, 6'd0, 4'b0001);
        end
        repeat (3) @(posedge clk_in);
        check("restart_pulses", 32'(done_pulses - p0), 1);

        // 6: reset in the middle of a frame
        send(1'b0, 8'h2C);
        for (int i = 0; i < 300; i++) send(1'b1, 8'(i));
        @(posedge clk_in); #1;
        dc_in = 1'b1; byte_rdy_in = 1'b1; rst_n_in = 1'b0;
        @(negedge clk_in); #1;
        check("midrst_en", 32'(wr_en_out), 0);
        check("midrst_done", 32'(wr_done_out), 0);
        @(posedge clk_in); #1 byte_rdy_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        send(1'b1, 8'h33); check("postrst_en", 32'(cap_en), 0);
        send(1'b1, 8'h44); check("postrst_addr", 32'(cap_addr), 0);
        send(1'b0, 8'h2C);
        send(1'b1, 8'h55); lit("postrst_first", 9'h001, 6'd0, 4'b0001);

        repeat (2) @(posedge clk_in);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
